// File: rtl/stream_cipher_pkg.sv
// Definitions shared by the stream-cipher interface FSM and the output holder.
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROCESSING = 2'd1,
    DONE       = 2'd2
  } interface_state_t;

  localparam int BYTE_W_DEFAULT = 8;

endpackage

// File: rtl/holder_buffer.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module holder_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             we_i,
  input  logic [IW-1:0]    widx_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IW-1:0]    ridx_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/output_holder.sv
// Collects WORD_BYTES cipher bytes while PROCESSING, then presents them byte-wise in DONE.
// Optional out_parity port when OUTPUT_HOLDER_PARITY_EN is defined.
module output_holder
  import stream_cipher_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int BYTE_W     = BYTE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  interface_state_t  interface_state,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_in_valid,
  output logic              byte_in_ready,
  output logic              output_is_ready,
  output logic [BYTE_W-1:0] out_byte,
  input  logic              out_next,
  output logic              out_last,
  input  logic              output_acknowledge,
`ifdef OUTPUT_HOLDER_PARITY_EN
  output logic              out_parity,
`endif
  output logic              overflow
);

  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int RW = $clog2(WORD_BYTES);
  localparam logic [CW-1:0] WB_FULL = CW'(WORD_BYTES);
  localparam logic [CW-1:0] WB_LAST_WR = CW'(WORD_BYTES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(WORD_BYTES - 1);

  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [RW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              ready_q, ready_d;
  logic              overflow_q, overflow_d;
  logic              is_proc, is_done, accept, ack_done;
  logic [BYTE_W-1:0] rd_data;

  assign is_proc       = (interface_state == PROCESSING);
  assign is_done       = (interface_state == DONE);
  assign byte_in_ready = is_proc && (wr_cnt_q < WB_FULL);
  assign accept        = byte_in_valid && byte_in_ready;
  assign ack_done      = is_done && output_acknowledge;

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    ready_d    = ready_q;
    overflow_d = overflow_q;
    if (byte_in_valid && is_proc && (wr_cnt_q == WB_FULL)) overflow_d = 1'b1;
    // Acknowledge takes priority over a coincident out_next.
    if (ack_done) begin
      wr_cnt_d = '0;
      rd_ptr_d = '0;
      ready_d  = 1'b0;
    end else begin
      if (accept) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_q == WB_LAST_WR) ready_d = 1'b1;
      end
      if (is_done && out_next) begin
        rd_ptr_d = (rd_ptr_q == RD_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  holder_buffer #(
    .DEPTH (WORD_BYTES),
    .WIDTH (BYTE_W),
    .IW    (RW)
  ) u_buf (
    .clk     (clk),
    .nrst    (nrst),
    .we_i    (accept),
    .widx_i  (wr_cnt_q[RW-1:0]),
    .wdata_i (byte_in),
    .ridx_i  (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign output_is_ready = ready_q;
  assign overflow        = overflow_q;
  assign out_byte        = is_done ? rd_data : '0;
  assign out_last        = is_done && (rd_ptr_q == RD_LAST);

`ifdef OUTPUT_HOLDER_PARITY_EN
  assign out_parity = ^out_byte;
`endif

endmodule

// File: tb/tb_output_holder.sv
// Directed self-checking bench for output_holder with WORD_BYTES=4.
module tb_output_holder;
  import stream_cipher_pkg::*;

  logic             clk;
  logic             nrst;
  interface_state_t interface_state;
  logic [7:0]       byte_in;
  logic             byte_in_valid;
  logic             byte_in_ready;
  logic             output_is_ready;
  logic [7:0]       out_byte;
  logic             out_next;
  logic             out_last;
  logic             output_acknowledge;
  logic             overflow;
`ifdef OUTPUT_HOLDER_PARITY_EN
  logic             out_parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] word_exp [4];

  output_holder #(.WORD_BYTES(4), .BYTE_W(8)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .interface_state    (interface_state),
    .byte_in            (byte_in),
    .byte_in_valid      (byte_in_valid),
    .byte_in_ready      (byte_in_ready),
    .output_is_ready    (output_is_ready),
    .out_byte           (out_byte),
    .out_next           (out_next),
    .out_last           (out_last),
    .output_acknowledge (output_acknowledge),
`ifdef OUTPUT_HOLDER_PARITY_EN
    .out_parity         (out_parity),
`endif
    .overflow           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    word_exp[0] = 8'h11; word_exp[1] = 8'h22; word_exp[2] = 8'h33; word_exp[3] = 8'h44;
    nrst = 1'b1;
    interface_state = IDLE;
    byte_in = 8'h00;
    byte_in_valid = 1'b0;
    out_next = 1'b0;
    output_acknowledge = 1'b0;
    #1 nrst = 1'b0;
    #2;
    chk("rst_ready",    byte_in_ready, 0);
    chk("rst_oir",      output_is_ready, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk) nrst = 1'b1;

    // Fill 0x11..0x44 on consecutive cycles
    @(negedge clk);
    interface_state = PROCESSING;
    byte_in_valid = 1'b1;
    byte_in = 8'h11;
    #1 chk("fill_ready", byte_in_ready, 1);
    @(negedge clk) byte_in = 8'h22;
    @(negedge clk) byte_in = 8'h33;
    @(negedge clk) byte_in = 8'h44;
    #1 chk("fill_oir_before_last", output_is_ready, 0);
    @(negedge clk) byte_in_valid = 1'b0;
    #1;
    chk("fill_oir_after_last", output_is_ready, 1);
    chk("full_ready",          byte_in_ready, 0);
    chk("full_no_overflow",    overflow, 0);

    // Offer a byte while full
    @(negedge clk);
    byte_in_valid = 1'b1;
    byte_in = 8'h55;
    #1;
    chk("ovf_ready",  byte_in_ready, 0);
    chk("ovf_before", overflow, 0);
    @(negedge clk) byte_in_valid = 1'b0;
    #1 chk("ovf_latched", overflow, 1);
    @(negedge clk) #1 chk("ovf_sticky", overflow, 1);

    // Readout in DONE
    interface_state = DONE;
    #1;
    chk("rd_byte0", out_byte, 32'h11);
    chk("rd_last0", out_last, 0);
    for (int k = 1; k < 4; k++) begin
      out_next = 1'b1;
      @(negedge clk) out_next = 1'b0;
      #1;
      chk("rd_byte", out_byte, word_exp[k]);
      chk("rd_last", out_last, (k == 3) ? 1 : 0);
    end
    out_next = 1'b1;
    @(negedge clk) out_next = 1'b0;
    #1 chk("wrap_to0", out_byte, 32'h11);

    // Five pulses from rd_ptr=0 land on index 1
    out_next = 1'b1;
    repeat (5) @(negedge clk);
    out_next = 1'b0;
    #1;
    chk("wrap5_byte", out_byte, 32'h22);
    chk("wrap5_last", out_last, 0);

    // Ack beats simultaneous out_next at rd_ptr=2
    out_next = 1'b1;
    @(negedge clk) out_next = 1'b0;
    #1 chk("ack_pre_byte", out_byte, 32'h33);
    out_next = 1'b1;
    output_acknowledge = 1'b1;
    @(negedge clk);
    out_next = 1'b0;
    output_acknowledge = 1'b0;
    #1;
    chk("ack_oir",      output_is_ready, 0);
    chk("ack_rd_ptr0",  out_byte, 32'h11);
    chk("ack_last",     out_last, 0);
    interface_state = PROCESSING;
    #1;
    chk("ack_wr_cnt0_ready", byte_in_ready, 1);
    chk("out_byte_not_done", out_byte, 0);

    // Reset mid-fill after two accepts
    byte_in_valid = 1'b1;
    byte_in = 8'h5A;
    @(negedge clk) byte_in = 8'hA5;
    @(negedge clk) byte_in_valid = 1'b0;
    #2;
    interface_state = DONE;
    nrst = 1'b0;
    #1;
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_oir",      output_is_ready, 0);
    chk("mid_rst_out_byte", out_byte, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_ready",    byte_in_ready, 0);
    interface_state = IDLE;
    @(negedge clk) nrst = 1'b1;

    // Inputs ignored in IDLE and DONE
    byte_in_valid = 1'b1;
    byte_in = 8'hAA;
    #1 chk("idle_ready", byte_in_ready, 0);
    @(negedge clk) #1 chk("idle_no_ovf", overflow, 0);
    interface_state = DONE;
    #1 chk("done_ready", byte_in_ready, 0);
    @(negedge clk);
    byte_in_valid = 1'b0;
    #1;
    chk("done_no_write", out_byte, 0);
    chk("done_no_ovf",   overflow, 0);
    chk("done_no_oir",   output_is_ready, 0);

    // Fresh word; out_next/ack outside DONE must be ignored
    interface_state = PROCESSING;
    out_next = 1'b1;
    output_acknowledge = 1'b1;
    byte_in_valid = 1'b1;
    byte_in = 8'h01;
    @(negedge clk) byte_in = 8'h03;
    @(negedge clk) byte_in = 8'h05;
    #1 chk("fresh_oir_after2", output_is_ready, 0);
    @(negedge clk) byte_in = 8'h07;
    #1 chk("fresh_oir_after3", output_is_ready, 0);
    @(negedge clk);
    byte_in_valid = 1'b0;
    out_next = 1'b0;
    output_acknowledge = 1'b0;
    #1 chk("fresh_oir_after4", output_is_ready, 1);
    interface_state = DONE;
    #1 chk("fresh_byte0", out_byte, 32'h01);
`ifdef OUTPUT_HOLDER_PARITY_EN
    chk("parity_01", out_parity, 1);
`endif
    out_next = 1'b1;
    @(negedge clk) out_next = 1'b0;
    #1 chk("fresh_byte1", out_byte, 32'h03);
`ifdef OUTPUT_HOLDER_PARITY_EN
    chk("parity_03", out_parity, 0);
`endif
    output_acknowledge = 1'b1;
    @(negedge clk) output_acknowledge = 1'b0;
    #1 chk("final_ack_oir", output_is_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
